// File: rtl/greedy_action_select_if.sv
// Request/response and action-RAM read bundle for the greedy selector.
// master = requester side (also supplies RAM read data), slave = selector.
interface greedy_action_select_if #(
    parameter int DATA_W  = 16,
    parameter int STATE_W = 4,
    parameter int ACT_W   = 2
);
    logic                       start;
    logic [STATE_W-1:0]         state;
    logic [7:0]                 epsilon;
    logic                       ram_en;
    logic [STATE_W+ACT_W-1:0]   ram_rd_addr;
    logic [DATA_W-1:0]          ram_data;
    logic                       busy;
    logic                       done;
    logic [ACT_W-1:0]           action;
    logic [DATA_W-1:0]          max_q;
    logic                       explore;

    modport master (
        output start, state, epsilon, ram_data,
        input  ram_en, ram_rd_addr, busy, done,
        input  action, max_q, explore
    );

    modport slave (
        input  start, state, epsilon, ram_data,
        output ram_en, ram_rd_addr, busy, done,
        output action, max_q, explore
    );
endinterface

// File: rtl/greedy_action_select.sv
// Epsilon-greedy action selector: streams the Q-values of one state out of
// the action RAM, tracks the signed maximum, optionally explores randomly.
module greedy_action_select #(
    parameter int         DATA_W    = 16,
    parameter int         STATE_W   = 4,
    parameter int         ACT_W     = 2,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic                   clk,
    input logic                   rst,
    greedy_action_select_if.slave bus
);

    localparam int         AW   = STATE_W + ACT_W;
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
    localparam logic [ACT_W-1:0] LAST = {ACT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fsm_e;

    fsm_e               fsm_q;
    logic [7:0]         lfsr_q;
    logic [7:0]         lfsr_d;
    logic               ram_en_q;
    logic [AW-1:0]      addr_q;
    logic               busy_q;
    logic               done_q;
    logic               exp_q;
    logic [ACT_W-1:0]   rnd_q;
    logic [DATA_W-1:0]  run_max_q;
    logic [DATA_W-1:0]  run_max_d;
    logic [ACT_W-1:0]   run_idx_q;
    logic [ACT_W-1:0]   run_idx_d;
    logic [ACT_W-1:0]   cmp_idx;
    logic               cmp_vld;
    logic               take;
    logic [ACT_W-1:0]   action_q;
    logic [DATA_W-1:0]  max_q_q;
    logic               explore_q;

    // Next LFSR value: right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    end

    // Running-max update for the Q-value currently on ram_data.
    // Data trails the issued address by one cycle, so the index under
    // comparison is the previous low address bits; DRAIN sees the last one.
    always_comb begin
        cmp_vld   = 1'b0;
        cmp_idx   = addr_q[ACT_W-1:0] - 1'b1;
        take      = 1'b0;
        run_max_d = run_max_q;
        run_idx_d = run_idx_q;
        if (fsm_q == DRAIN) begin
            cmp_vld = 1'b1;
            cmp_idx = LAST;
        end else if (fsm_q == ISSUE) begin
            cmp_vld = (addr_q[ACT_W-1:0] != '0);
        end
        if (cmp_vld) begin
            take = (cmp_idx == '0) ||
                   ($signed(bus.ram_data) > $signed(run_max_q));
        end
        if (take) begin
            run_max_d = bus.ram_data;
            run_idx_d = cmp_idx;
        end
    end

    // Control FSM, LFSR and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= IDLE;
            lfsr_q    <= SEED;
            ram_en_q  <= 1'b0;
            addr_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            exp_q     <= 1'b0;
            rnd_q     <= '0;
            run_max_q <= '0;
            run_idx_q <= '0;
            action_q  <= '0;
            max_q_q   <= '0;
            explore_q <= 1'b0;
        end else begin
            lfsr_q    <= lfsr_d;
            run_max_q <= run_max_d;
            run_idx_q <= run_idx_d;
            unique case (fsm_q)
                IDLE: begin
                    if (bus.start) begin
                        fsm_q    <= ISSUE;
                        ram_en_q <= 1'b1;
                        addr_q   <= {bus.state, {ACT_W{1'b0}}};
                        busy_q   <= 1'b1;
                        exp_q    <= (lfsr_q < bus.epsilon);
                        rnd_q    <= lfsr_q[ACT_W-1:0];
                    end
                end
                ISSUE: begin
                    if (addr_q[ACT_W-1:0] == LAST) begin
                        fsm_q <= DRAIN;
                    end else begin
                        addr_q[ACT_W-1:0] <= addr_q[ACT_W-1:0] + 1'b1;
                    end
                end
                DRAIN: begin
                    fsm_q     <= DONE;
                    ram_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    max_q_q   <= run_max_d;
                    action_q  <= exp_q ? rnd_q : run_idx_d;
                    explore_q <= exp_q;
                end
                DONE: begin
                    fsm_q  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ram_en      = ram_en_q;
    assign bus.ram_rd_addr = addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.action      = action_q;
    assign bus.max_q       = max_q_q;
    assign bus.explore     = explore_q;

endmodule
